egress_count: RTL and testbench
===============================

# egress_count

Egress stage downstream of the D0/D1 destination FIFOs. Drains both FIFOs with a fair round-robin pop, classifies every popped word by destination and by virtual channel, and keeps per-class word counters. Counters are read one at a time through a request/valid port, enabled only while the condition state machine reports idle, so the bench can check end-to-end conservation of words through the fabric.

## Interface

Parameters:
- BW, 6, word width of D0/D1 data.
- CW, 5, counter width; counters wrap modulo 2^CW.
- VC_BIT, 4, index of the data bit carrying the VC id (0 = VC0, 1 = VC1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_L  input  1  synchronous, active-low reset (sampled on clk rising edge).
- D0_empty  input  1  D0 FIFO empty flag.
- D1_empty  input  1  D1 FIFO empty flag.
- D0_data_out  input  BW  D0 FIFO read data, valid the cycle after D0_rd.
- D1_data_out  input  BW  D1 FIFO read data, valid the cycle after D1_rd.
- idle  input  1  idle_out_cond from the condition state machine.
- req  input  1  counter read request, one-cycle pulse.
- idx  input  2  counter select: 0 = D0, 1 = D1, 2 = VC0, 3 = VC1.
- D0_rd  output  1  pop strobe to D0 FIFO.
- D1_rd  output  1  pop strobe to D1 FIFO.
- count_out  output  CW  selected counter value.
- valid  output  1  count_out valid strobe.

## Operation

- Reset (reset_L = 0 at an edge): D0_rd = D1_rd = 0, count_out = 0, valid = 0, all four counters = 0, round-robin pointer = D0, capture pipeline flags cleared. A reset mid-operation discards any in-flight capture, so a word popped in the cycle before reset is not counted.
- The pop arbiter is combinational from registered state and the empty flags. At most one of D0_rd or D1_rd is high in any cycle.
  - Only one FIFO non-empty: pop that FIFO.
  - Both FIFOs non-empty: pop the FIFO named by the pointer. The pointer then toggles to the other FIFO.
  - Both FIFOs empty: no pop, and the pointer holds.
  - The pointer changes only on a pop, and after a pop it always points away from the FIFO just popped.
  - D0_rd and D1_rd are forced low while reset_L = 0.
- Capture stage: rd_q0/rd_q1 are registered copies of D0_rd/D1_rd. In the cycle where rd_qN = 1:
  - cnt_DN increments.
  - The data bit at VC_BIT of DN_data_out selects whether cnt_VC0 or cnt_VC1 increments.
  - Exactly two counters increment per popped word.
- Counters are CW bits and wrap from 2^CW-1 to 0; there is no saturation or overflow flag.
- Read port:
  - On an edge where req = 1 and idle = 1: count_out is registered with counter[idx] and valid = 1 for one cycle.
  - If the selected counter increments on the same edge, count_out returns the pre-increment value.
  - If req = 1 and idle = 0: the request is dropped. valid = 0 and count_out holds its previous value.
  - If req = 0: valid = 0 and count_out holds.
- Invariant at any quiescent point with no wraps: cnt_D0 + cnt_D1 = cnt_VC0 + cnt_VC1.

## Timing

- Pop latency: a FIFO that becomes non-empty at edge k is popped in the cycle after edge k. D0_rd/D1_rd are combinational from the empty flags and the pointer.
- Count latency: a pop in cycle n (rd high) is captured at the edge ending cycle n+1. The counter value is visible internally from cycle n+2.
- Read latency: req sampled at edge k gives valid/count_out in the cycle after edge k, for exactly one cycle.
- Throughput: one word per cycle total when either FIFO has data. With sustained data in both FIFOs, pops alternate D0, D1, D0, and so on.

## Test plan

- Reset: hold reset_L = 0 for 2 cycles with both FIFOs non-empty -> D0_rd = D1_rd = 0, valid = 0, count_out = 0; a read of idx 0..3 after release returns 0 for every counter.
- Single-FIFO drain: 5 words in D0 (VC bit = 1,0,1,1,0), D1 empty -> D0_rd high for 5 consecutive cycles, D1_rd = 0; afterwards, reading with idle = 1 gives D0 = 5, D1 = 0, VC0 = 2, VC1 = 3.
- Fairness: both FIFOs hold 4 words each -> pop sequence D0, D1, D0, D1, D0, D1, D0, D1; D0 = 4 and D1 = 4; counters never both increment for the same destination in adjacent cycles.
- Wrap: pop 33 words from D1, all on VC1 -> D1 = 1, VC1 = 1 (33 mod 32).
- Read gating: req = 1 with idx = 0 while idle = 0 -> valid stays 0 and count_out is unchanged; the same request with idle = 1 -> valid = 1 in the next cycle with the correct value.
- Reset mid-operation: assert reset_L = 0 in the cycle right after a D0 pop -> that word is not counted and all counters read 0 after reset.

Source files
------------

// File: rtl/egress_count.sv
// egress_count: drains the D0/D1 destination FIFOs with a round-robin pop,
// counts popped words per destination and per virtual channel, and serves
// counter reads through a req/valid port gated by the idle condition.
module egress_count #(
   parameter int unsigned BW     = 6,
   parameter int unsigned CW     = 5,
   parameter int unsigned VC_BIT = 4
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          D0_empty,
   input  logic          D1_empty,
   input  logic [BW-1:0] D0_data_out,
   input  logic [BW-1:0] D1_data_out,
   input  logic          idle,
   input  logic          req,
   input  logic [1:0]    idx,
   output logic          D0_rd,
   output logic          D1_rd,
   output logic [CW-1:0] count_out,
   output logic          valid
);

   localparam int unsigned IW = 2;

   logic          r_ptr;       // 0 = D0 next on contention, 1 = D1
   logic          r_rd_q0;
   logic          r_rd_q1;
   logic [CW-1:0] r_cnt_d0;
   logic [CW-1:0] r_cnt_d1;
   logic [CW-1:0] r_cnt_vc0;
   logic [CW-1:0] r_cnt_vc1;
   logic [CW-1:0] r_count_out;
   logic          r_valid;

   logic          w_pop0;
   logic          w_pop1;
   logic          w_vc_d0;
   logic          w_vc_d1;
   logic [IW-1:0] w_vc0_inc;
   logic [IW-1:0] w_vc1_inc;
   logic [CW-1:0] w_sel_cnt;

   // Round-robin pop arbiter: the lone non-empty FIFO wins, the pointer breaks ties
   always_comb begin
      w_pop0 = 1'b0;
      w_pop1 = 1'b0;
      if (reset_L) begin
         w_pop0 = !D0_empty && (D1_empty || (r_ptr == 1'b0));
         w_pop1 = !D1_empty && (D0_empty || (r_ptr == 1'b1));
      end
   end

   assign D0_rd = w_pop0;
   assign D1_rd = w_pop1;

   // VC classification of the word captured this cycle
   always_comb begin
      w_vc_d0   = D0_data_out[VC_BIT];
      w_vc_d1   = D1_data_out[VC_BIT];
      w_vc0_inc = IW'(r_rd_q0 && !w_vc_d0) + IW'(r_rd_q1 && !w_vc_d1);
      w_vc1_inc = IW'(r_rd_q0 &&  w_vc_d0) + IW'(r_rd_q1 &&  w_vc_d1);
   end

   // Counter selection for the read port
   always_comb begin
      w_sel_cnt = r_cnt_d0;
      case (idx)
         2'd0:    w_sel_cnt = r_cnt_d0;
         2'd1:    w_sel_cnt = r_cnt_d1;
         2'd2:    w_sel_cnt = r_cnt_vc0;
         default: w_sel_cnt = r_cnt_vc1;
      endcase
   end

   // Pointer update: after a pop always point away from the FIFO just popped
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_ptr <= 1'b0;
      end else if (w_pop0) begin
         r_ptr <= 1'b1;
      end else if (w_pop1) begin
         r_ptr <= 1'b0;
      end
   end

   // Capture pipeline and per-class counters (wrap modulo 2^CW)
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_rd_q0   <= 1'b0;
         r_rd_q1   <= 1'b0;
         r_cnt_d0  <= '0;
         r_cnt_d1  <= '0;
         r_cnt_vc0 <= '0;
         r_cnt_vc1 <= '0;
      end else begin
         r_rd_q0   <= w_pop0;
         r_rd_q1   <= w_pop1;
         r_cnt_d0  <= r_cnt_d0  + CW'(r_rd_q0);
         r_cnt_d1  <= r_cnt_d1  + CW'(r_rd_q1);
         r_cnt_vc0 <= r_cnt_vc0 + CW'(w_vc0_inc);
         r_cnt_vc1 <= r_cnt_vc1 + CW'(w_vc1_inc);
      end
   end

   // Read port: sample the pre-increment counter when idle, else drop the request
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_count_out <= '0;
         r_valid     <= 1'b0;
      end else if (req && idle) begin
         r_count_out <= w_sel_cnt;
         r_valid     <= 1'b1;
      end else begin
         r_valid     <= 1'b0;
      end
   end

   assign count_out = r_count_out;
   assign valid     = r_valid;

endmodule

// File: tb/tb_egress_count.sv
// Self-checking bench for egress_count: bench-side FIFO models feed D0/D1,
// counter read-backs are compared against a table of hand-computed values.
module tb_egress_count;

   localparam int unsigned BW = 6;
   localparam int unsigned CW = 5;

   logic          clk = 1'b0;
   logic          reset_L;
   logic          D0_empty;
   logic          D1_empty;
   logic [BW-1:0] D0_data_out;
   logic [BW-1:0] D1_data_out;
   logic          idle;
   logic          req;
   logic [1:0]    idx;
   logic          D0_rd;
   logic          D1_rd;
   logic [CW-1:0] count_out;
   logic          valid;

   int errors = 0;
   int checks = 0;

   // FIFO models
   logic [BW-1:0] mem0 [0:63];
   logic [BW-1:0] mem1 [0:63];
   int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
   logic fifo_clr = 1'b0;

   assign D0_empty = (wr0 == rd0);
   assign D1_empty = (wr1 == rd1);

   always #5 clk = ~clk;

   egress_count dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .D0_empty    (D0_empty),
      .D1_empty    (D1_empty),
      .D0_data_out (D0_data_out),
      .D1_data_out (D1_data_out),
      .idle        (idle),
      .req         (req),
      .idx         (idx),
      .D0_rd       (D0_rd),
      .D1_rd       (D1_rd),
      .count_out   (count_out),
      .valid       (valid)
   );

   always @(posedge clk) begin
      if (fifo_clr) begin
         rd0 <= wr0;
         rd1 <= wr1;
      end else begin
         if (D0_rd && (wr0 != rd0)) begin
            D0_data_out <= mem0[rd0 % 64];
            rd0 <= rd0 + 1;
         end
         if (D1_rd && (wr1 != rd1)) begin
            D1_data_out <= mem1[rd1 % 64];
            rd1 <= rd1 + 1;
         end
      end
   end

   typedef struct {
      int         phase;
      logic [1:0] idx;
      logic [4:0] exp;
   } rd_vec_t;

   rd_vec_t vecs [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push0(input logic [BW-1:0] w);
      mem0[wr0 % 64] = w;
      wr0++;
   endtask

   task automatic push1(input logic [BW-1:0] w);
      mem1[wr1 % 64] = w;
      wr1++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_L = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic read_cnt(input logic [1:0] i, input int exp, input string name);
      @(negedge clk);
      req  = 1'b1;
      idle = 1'b1;
      idx  = i;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      chk({name, "_valid"}, int'(valid), 1);
      chk(name, int'(count_out), exp);
   endtask

   task automatic run_table(input int p);
      foreach (vecs[k]) begin
         if (vecs[k].phase == p)
            read_cnt(vecs[k].idx, int'(vecs[k].exp), $sformatf("p%0d_idx%0d", p, vecs[k].idx));
      end
   endtask

   initial begin
      // phase 1 reset, 2 single drain, 3 fairness, 4 wrap, 6 reset mid-op
      vecs.push_back('{1, 2'd0, 5'd0}); vecs.push_back('{1, 2'd1, 5'd0});
      vecs.push_back('{1, 2'd2, 5'd0}); vecs.push_back('{1, 2'd3, 5'd0});
      vecs.push_back('{2, 2'd0, 5'd5}); vecs.push_back('{2, 2'd1, 5'd0});
      vecs.push_back('{2, 2'd2, 5'd2}); vecs.push_back('{2, 2'd3, 5'd3});
      vecs.push_back('{3, 2'd0, 5'd4}); vecs.push_back('{3, 2'd1, 5'd4});
      vecs.push_back('{3, 2'd2, 5'd5}); vecs.push_back('{3, 2'd3, 5'd3});
      vecs.push_back('{4, 2'd0, 5'd0}); vecs.push_back('{4, 2'd2, 5'd0});
      vecs.push_back('{4, 2'd3, 5'd1}); vecs.push_back('{4, 2'd1, 5'd1});
      vecs.push_back('{6, 2'd0, 5'd0}); vecs.push_back('{6, 2'd1, 5'd0});
      vecs.push_back('{6, 2'd2, 5'd0}); vecs.push_back('{6, 2'd3, 5'd0});

      reset_L = 1'b0;
      idle    = 1'b1;
      req     = 1'b0;
      idx     = 2'd0;

      // Reset held with both FIFOs non-empty
      @(negedge clk);
      push0(6'h10); push0(6'h01); push1(6'h11); push1(6'h02);
      #1;
      chk("rst_d0_rd", int'(D0_rd), 0);
      chk("rst_d1_rd", int'(D1_rd), 0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_d0_rd2", int'(D0_rd), 0);
      chk("rst_d1_rd2", int'(D1_rd), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_count_out", int'(count_out), 0);
      fifo_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fifo_clr = 1'b0;
      reset_L  = 1'b1;
      run_table(1);

      // Single-FIFO drain: VC bits 1,0,1,1,0
      do_reset();
      push0(6'h13); push0(6'h05); push0(6'h1f); push0(6'h30); push0(6'h2a);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("drain_d0_rd_%0d", i), int'(D0_rd), 1);
         chk($sformatf("drain_d1_rd_%0d", i), int'(D1_rd), 0);
         @(negedge clk);
      end
      chk("drain_d0_rd_done", int'(D0_rd), 0);
      repeat (3) @(negedge clk);
      run_table(2);

      // Fairness: D0 VC bits 1,1,0,0; D1 VC bits 0,0,0,1
      do_reset();
      push0(6'h10); push0(6'h11); push0(6'h02); push0(6'h03);
      push1(6'h04); push1(6'h05); push1(6'h06); push1(6'h17);
      #1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rr_d0_rd_%0d", i), int'(D0_rd), (i % 2 == 0) ? 1 : 0);
         chk($sformatf("rr_d1_rd_%0d", i), int'(D1_rd), (i % 2 == 1) ? 1 : 0);
         @(negedge clk);
      end
      chk("rr_idle_d0", int'(D0_rd), 0);
      chk("rr_idle_d1", int'(D1_rd), 0);
      repeat (3) @(negedge clk);
      run_table(3);

      // Wrap: 33 words from D1, all VC1
      do_reset();
      for (int i = 0; i < 33; i++) push1(6'h10);
      repeat (40) @(negedge clk);
      run_table(4);

      // Read gating: count_out holds 1 from the last read, D0 counter is 0
      @(negedge clk);
      req  = 1'b1;
      idle = 1'b0;
      idx  = 2'd0;
      @(posedge clk);
      @(negedge clk);
      req  = 1'b0;
      idle = 1'b1;
      chk("gate_valid", int'(valid), 0);
      chk("gate_hold", int'(count_out), 1);
      read_cnt(2'd0, 0, "gate_open");
      @(negedge clk);
      chk("valid_one_cycle", int'(valid), 0);

      // Read on the same edge as the D0 increment returns the pre-increment value
      push0(6'h10);
      @(posedge clk);
      @(negedge clk);
      req = 1'b1;
      idx = 2'd0;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      chk("preinc_valid", int'(valid), 1);
      chk("preinc_value", int'(count_out), 0);
      read_cnt(2'd0, 1, "postinc_d0");
      read_cnt(2'd3, 2, "postinc_vc1");

      // Reset in the cycle after a D0 pop discards the captured word
      do_reset();
      push0(6'h10);
      #1;
      chk("midrst_pop", int'(D0_rd), 1);
      @(posedge clk);
      @(negedge clk);
      reset_L = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_L = 1'b1;
      repeat (3) @(negedge clk);
      run_table(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
